fetch: RTL and testbench

//  Instruction fetch stage feeding decode. Reads 32-bit aligned words from the instruction bus,

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch.sv | 128 ++++++++++++
 tb/tb_fetch.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned RV          = 32;
    localparam int unsigned QDEPTH_DEF  = 4;
    localparam logic [RV-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [15:0]   ins;
        logic [RV-1:0] pc;
        logic          fault;
    } parcel_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WAIT_DISCARD
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction bus plus decode-side handshake of the fetch stage.
interface fetch_if;
    import fetch_pkg::*;

    logic          ifetch_req;
    logic [RV-1:0] ifetch_addr;
    logic          ifetch_ack;
    logic [31:0]   ifetch_data;
    logic          ifetch_err;
    logic          next;
    logic          redirect;
    logic [RV-1:0] redirect_pc;
    logic [15:0]   ins;
    logic [RV-1:0] ins_pc;
    logic          ins_fault;
    logic          idone;

    modport master (
        output ifetch_req, ifetch_addr, ins, ins_pc, ins_fault, idone,
        input  ifetch_ack, ifetch_data, ifetch_err, next, redirect, redirect_pc
    );

    modport slave (
        input  ifetch_req, ifetch_addr, ins, ins_pc, ins_fault, idone,
        output ifetch_ack, ifetch_data, ifetch_err, next, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular parcel queue: up to two pushes and one pop per cycle, registered head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned   DEPTH    = QDEPTH_DEF,
    parameter logic [RV-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push0_i,
    input  logic                   push1_i,
    input  parcel_t                data0_i,
    input  parcel_t                data1_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output parcel_t                head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    parcel_t        mem_q [DEPTH];
    logic [CW-1:0]  rd_q, rd_d, wr_q, wr_d, wr1, cnt_pop;
    parcel_t        head_q, head_d;

    // Next pointers and the parcel that will sit at the head next cycle.
    always_comb begin
        wr1     = wr_q + CW'(push0_i);
        wr_d    = wr1 + CW'(push1_i);
        rd_d    = rd_q + CW'(pop_i);
        cnt_pop = wr_q - rd_d;
        head_d  = head_q;
        if (flush_i) begin
            rd_d = '0;
            wr_d = '0;
        end else if (cnt_pop != '0) begin
            head_d = mem_q[rd_d[PW-1:0]];
        end else if (push0_i) begin
            head_d = data0_i;
        end else if (push1_i) begin
            head_d = data1_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            head_q <= '{ins: 16'h0, pc: RESET_PC, fault: 1'b0};
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_q[PW-1:0]] <= data0_i;
        if (push1_i) mem_q[wr1[PW-1:0]]  <= data1_i;
    end

    assign count_o = wr_q - rd_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: word reads split into 16-bit parcels, redirect and fault handling.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned   QDEPTH   = QDEPTH_DEF,
    parameter logic [RV-1:0] RESET_PC = RESET_PC_DEF
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic          req_q, req_d;
    logic [RV-1:0] addr_q, addr_d;
    logic [RV-1:0] pc_q, pc_d;
    logic          fault_q, fault_d;

    logic          push0, push1, flush, pop_c;
    logic          ack_v, drop, good, can_issue;
    logic [CW-1:0] count, free;
    parcel_t       lo_p, hi_p, head;
    logic          unused_rpc0;

    // Bit 0 of the redirect target is ignored.
    assign unused_rpc0 = bus.redirect_pc[0];

    fetch_queue #(.DEPTH(QDEPTH), .RESET_PC(RESET_PC)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push0_i (push0),
        .push1_i (push1),
        .data0_i (lo_p),
        .data1_i (hi_p),
        .pop_i   (pop_c),
        .flush_i (flush),
        .count_o (count),
        .head_o  (head)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        push0     = 1'b0;
        push1     = 1'b0;
        flush     = 1'b0;

        pop_c = bus.next && (count != '0) && !bus.redirect;
        ack_v = bus.ifetch_ack && (state_q != S_IDLE);
        drop  = ack_v && ((state_q == S_WAIT_DISCARD) || bus.redirect);
        good  = ack_v && !drop;

        lo_p = '{ins: bus.ifetch_data[15:0],  pc: addr_q,             fault: bus.ifetch_err};
        hi_p = '{ins: bus.ifetch_data[31:16], pc: addr_q + RV'(2),    fault: bus.ifetch_err};

        if (good) begin
            push0   = !pc_q[1];
            push1   = 1'b1;
            pc_d    = addr_q + RV'(4);
            fault_d = bus.ifetch_err;
        end
        if (bus.redirect) begin
            flush   = 1'b1;
            pc_d    = {bus.redirect_pc[RV-1:1], 1'b0};
            fault_d = 1'b0;
        end

        // A redirect empties the queue this cycle, so all slots count as free.
        free      = bus.redirect ? CW'(QDEPTH) : CW'(QDEPTH) - count;
        can_issue = (free >= CW'(2)) && !fault_d;

        case (state_q)
            S_IDLE: begin
                if (can_issue) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = {pc_d[RV-1:2], 2'b00};
                end
            end
            S_WAIT, S_WAIT_DISCARD: begin
                if (ack_v) begin
                    if (drop && can_issue) begin
                        state_d = S_WAIT;
                        addr_d  = {pc_d[RV-1:2], 2'b00};
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end else if (bus.redirect) begin
                    state_d = S_WAIT_DISCARD;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= {RESET_PC[RV-1:2], 2'b00};
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign bus.ifetch_req  = req_q;
    assign bus.ifetch_addr = addr_q;
    assign bus.ins         = head.ins;
    assign bus.ins_pc      = head.pc;
    assign bus.ins_fault   = head.fault;
    assign bus.idone       = pop_c;

endmodule

// File: tb/tb_fetch.sv
// Fetch-stage bench: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch;
    import fetch_pkg::*;

    localparam int unsigned   D   = 4;
    localparam logic [31:0]   RPC = 32'h0;

    typedef struct {
        logic [15:0] ins;
        logic [31:0] pc;
        logic        f;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch #(.QDEPTH(D), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: expected queue contents and bus state.
    ent_t        mq[$];
    logic        m_out, m_disc, m_flt;
    logic [31:0] m_pc, m_addr;
    bit          trap_pend;
    int          pops;

    // Parcels actually delivered by the DUT.
    logic [15:0] lg_ins[$];
    logic [31:0] lg_pc[$];
    logic        lg_f[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check idone/head, advance model, check bus after the edge.
    task automatic step(input bit rs, input bit nx, input bit rd, input logic [31:0] rpc,
                        input bit ak, input logic [31:0] dat, input bit er);
        int free;
        bit exp_id, acked, drop, issue;
        reset           = !rs;
        bus.next        = nx;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.ifetch_ack  = ak;
        bus.ifetch_data = dat;
        bus.ifetch_err  = er;
        #1;
        exp_id = nx && (mq.size() > 0) && !rd;
        chk("idone", bus.idone, exp_id);
        if (exp_id) begin
            chk("ins", bus.ins, mq[0].ins);
            chk("ins_pc", bus.ins_pc, mq[0].pc);
            chk("ins_fault", bus.ins_fault, mq[0].f);
            lg_ins.push_back(bus.ins);
            lg_pc.push_back(bus.ins_pc);
            lg_f.push_back(bus.ins_fault);
            if (mq[0].f) trap_pend = 1'b1;
            pops++;
        end
        if (rs) begin
            mq.delete();
            m_out  = 1'b0;
            m_disc = 1'b0;
            m_flt  = 1'b0;
            m_pc   = RPC;
        end else begin
            free = rd ? int'(D) : int'(D) - mq.size();
            if (exp_id) void'(mq.pop_front());
            acked = m_out && ak;
            drop  = acked && (m_disc || rd);
            if (acked && !drop) begin
                if (!m_pc[1]) mq.push_back('{dat[15:0], m_addr, er});
                mq.push_back('{dat[31:16], m_addr + 32'd2, er});
                m_pc  = m_addr + 32'd4;
                m_flt = er;
            end
            if (acked) m_disc = 1'b0;
            if (rd) begin
                mq.delete();
                m_pc  = {rpc[31:1], 1'b0};
                m_flt = 1'b0;
                if (m_out && !ak) m_disc = 1'b1;
            end
            issue = (!m_out || drop) && (free >= 2) && !m_flt;
            m_out = (m_out && !ak) || issue;
            if (issue) m_addr = {m_pc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        chk("req", bus.ifetch_req, m_out);
        if (m_out) chk("addr", bus.ifetch_addr, m_addr);
        if (rs) chk("rst_ins_pc", bus.ins_pc, RPC);
    endtask

    // n cycles acking every pending request with random data.
    task automatic run(input int n, input bit nx, input bit er);
        for (int i = 0; i < n; i++)
            step(1'b0, nx, 1'b0, 32'h0, bus.ifetch_req, $urandom, er);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] words [2];
        int          k, n0;
        bit          rs, rd, ak;
        logic [31:0] rpc;

        reset = 1'b0;
        bus.next = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.ifetch_ack = 1'b0; bus.ifetch_data = '0; bus.ifetch_err = 1'b0;
        m_out = 1'b0; m_disc = 1'b0; m_flt = 1'b0; m_pc = RPC; m_addr = RPC;
        trap_pend = 1'b0; pops = 0;
        @(posedge clk);
        #1;

        // Two words streamed straight through to decode.
        words[0] = 32'h2222_1111;
        words[1] = 32'h4444_3333;
        do_reset();
        chk("rst_req", bus.ifetch_req, 1'b0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            ak = bus.ifetch_req && (k < 2);
            step(1'b0, 1'b1, 1'b0, 32'h0, ak, ak ? words[k] : 32'h0, 1'b0);
            if (ak) k++;
        end
        chk("t1_n", lg_ins.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_ins", lg_ins[i], 64'h1111 * (i + 1));
            chk("t1_pc", lg_pc[i], 2 * i);
        end

        // Queue full with next held low: requests stop until two slots free up.
        do_reset();
        run(6, 1'b0, 1'b0);
        chk("t2_full_req", bus.ifetch_req, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        run(3, 1'b0, 1'b0);
        chk("t2_one_free", bus.ifetch_req, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_req", bus.ifetch_req, 1'b1);
        chk("t2_addr", bus.ifetch_addr, 32'h8);

        // Redirect to an odd parcel while a read is outstanding.
        step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
        chk("t3_hold", bus.ifetch_req, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hdead_beef, 1'b0);
        chk("t3_addr", bus.ifetch_addr, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'haaaa_bbbb, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t3_ins", lg_ins[$], 16'haaaa);
        chk("t3_pc", lg_pc[$], 32'h102);

        // Redirect and next together on a non-empty queue.
        run(2, 1'b0, 1'b0);
        n0 = lg_ins.size();
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_flush", lg_ins.size(), n0);

        // Faulted read stalls fetch until the trap redirect.
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        run(2, 1'b0, 1'b1);
        run(4, 1'b0, 1'b0);
        chk("t5_noreq", bus.ifetch_req, 1'b0);
        run(2, 1'b1, 1'b0);
        chk("t5_f0", lg_f[$-1], 1'b1);
        chk("t5_f1", lg_f[$], 1'b1);
        chk("t5_pc", lg_pc[$-1], 32'h10);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        chk("t5_req", bus.ifetch_req, 1'b1);
        chk("t5_addr", bus.ifetch_addr, 32'h40);
        trap_pend = 1'b0;

        // Reset with a request pending; a late ack must be ignored.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_req", bus.ifetch_req, 1'b0);
        n0 = lg_ins.size();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_6666, 1'b0);
        chk("t6_addr", bus.ifetch_addr, RPC);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_nopush", lg_ins.size(), n0);

        // Random traffic: stalls, redirects (incl. near wrap), faults, stray acks, resets.
        pops = 0;
        for (int i = 0; i < 4000; i++) begin
            rs  = ($urandom % 500) == 0;
            rd  = !rs && (trap_pend || (($urandom % 40) == 0));
            rpc = (($urandom % 4) == 0) ? 32'hffff_fff0 + ($urandom % 16) : $urandom;
            ak  = (bus.ifetch_req && (($urandom % 3) != 0)) || (($urandom % 50) == 0);
            if (rd || rs) trap_pend = 1'b0;
            step(rs, !rs && (($urandom % 4) != 0), rd, rpc, ak, $urandom, ($urandom % 16) == 0);
        end
        chk("liveness", pops >= 400, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
